// File: rtl/overflow_interval_table.sv
// Table of inclusive overflow address intervals with free-slot allocation, cursor replacement
// when full and registered multi-port range lookups. Optional macro OIT_DEDUP_EN absorbs duplicates.
module overflow_interval_table #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          wr_valid_i,
  output logic                          wr_ready_o,
  input  logic [ADDR_W-1:0]             wr_first_i,
  input  logic [ADDR_W-1:0]             wr_last_i,
  output logic                          wr_err_o,
  input  logic                          clr_valid_i,
  input  logic [ADDR_W-1:0]             clr_addr_i,
  input  logic                          flush_i,
  input  logic [NUM_PORTS-1:0]          lk_valid_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]   lk_addr_i,
  output logic [NUM_PORTS-1:0]          lk_valid_o,
  output logic [NUM_PORTS-1:0]          lk_in_range_o,
  output logic [NUM_PORTS-1:0]          lk_is_first_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o,
  output logic                          full_o,
  output logic                          overwrite_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [ADDR_W-1:0]    first_q [DEPTH];
  logic [ADDR_W-1:0]    first_d [DEPTH];
  logic [ADDR_W-1:0]    last_q  [DEPTH];
  logic [ADDR_W-1:0]    last_d  [DEPTH];
  logic [IdxW-1:0]      cursor_q, cursor_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 err_q, err_d;
  logic                 ovw_q, ovw_d;
  logic [NUM_PORTS-1:0] lk_valid_q, lk_valid_d;
  logic [NUM_PORTS-1:0] lk_in_range_q, lk_in_range_d;
  logic [NUM_PORTS-1:0] lk_is_first_q, lk_is_first_d;

  logic                 wr_accept, wr_bad, wr_dup;
  logic [DEPTH-1:0]     clr_hit, valid_kept;
  logic                 free_found;
  logic [IdxW-1:0]      free_idx, wr_idx;

  assign wr_ready_o = rst_ni & ~flush_i;
  assign wr_accept  = wr_valid_i & wr_ready_o;
  assign wr_bad     = wr_first_i > wr_last_i;

  // Clear acts on pre-existing entries; the free search then sees the slots it freed.
  always_comb begin
    clr_hit    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      clr_hit[i] = clr_valid_i & valid_q[i] & (first_q[i] == clr_addr_i);
    end
    valid_kept = valid_q & ~clr_hit;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!valid_kept[i]) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
  end

`ifdef OIT_DEDUP_EN
  always_comb begin
    wr_dup = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_kept[i] && first_q[i] == wr_first_i && last_q[i] == wr_last_i) begin
        wr_dup = 1'b1;
      end
    end
  end
`else
  assign wr_dup = 1'b0;
`endif

  always_comb begin
    valid_d  = valid_q;
    first_d  = first_q;
    last_d   = last_q;
    cursor_d = cursor_q;
    err_d    = wr_accept & wr_bad;
    ovw_d    = 1'b0;
    wr_idx   = free_idx;
    if (flush_i) begin
      valid_d  = '0;
      cursor_d = '0;
    end else begin
      valid_d = valid_kept;
      if (wr_accept && !wr_bad && !wr_dup) begin
        if (!free_found) begin
          wr_idx   = cursor_q;
          cursor_d = (cursor_q == IdxW'(DEPTH - 1)) ? '0 : cursor_q + IdxW'(1);
          ovw_d    = 1'b1;
        end
        valid_d[wr_idx] = 1'b1;
        first_d[wr_idx] = wr_first_i;
        last_d[wr_idx]  = wr_last_i;
      end
    end
    count_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      count_d = count_d + CntW'(valid_d[i]);
    end
  end

  // Lookups read the pre-update table, so results show old data for one cycle.
  always_comb begin
    logic [ADDR_W-1:0] addr;
    logic              hit_rng, hit_first;
    addr          = '0;
    hit_rng       = 1'b0;
    hit_first     = 1'b0;
    lk_valid_d    = '0;
    lk_in_range_d = '0;
    lk_is_first_d = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      addr      = lk_addr_i[p*ADDR_W +: ADDR_W];
      hit_rng   = 1'b0;
      hit_first = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (valid_q[i]) begin
          if (first_q[i] <= addr && addr <= last_q[i]) hit_rng = 1'b1;
          if (first_q[i] == addr) hit_first = 1'b1;
        end
      end
      lk_valid_d[p]    = lk_valid_i[p];
      lk_in_range_d[p] = lk_valid_i[p] & hit_rng;
      lk_is_first_d[p] = lk_valid_i[p] & hit_first;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q       <= '0;
      cursor_q      <= '0;
      count_q       <= '0;
      err_q         <= 1'b0;
      ovw_q         <= 1'b0;
      lk_valid_q    <= '0;
      lk_in_range_q <= '0;
      lk_is_first_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        first_q[i] <= '0;
        last_q[i]  <= '0;
      end
    end else begin
      valid_q       <= valid_d;
      first_q       <= first_d;
      last_q        <= last_d;
      cursor_q      <= cursor_d;
      count_q       <= count_d;
      err_q         <= err_d;
      ovw_q         <= ovw_d;
      lk_valid_q    <= lk_valid_d;
      lk_in_range_q <= lk_in_range_d;
      lk_is_first_q <= lk_is_first_d;
    end
  end

  assign count_o       = count_q;
  assign full_o        = (count_q == CntW'(DEPTH));
  assign wr_err_o      = err_q;
  assign overwrite_o   = ovw_q;
  assign lk_valid_o    = lk_valid_q;
  assign lk_in_range_o = lk_in_range_q;
  assign lk_is_first_o = lk_is_first_q;

endmodule

// File: doc/overflow_interval_table.md
# overflow_interval_table

- Parametrised table of overflow address intervals with explicit valid bits, free-slot allocation and oldest-entry replacement when full.
- Supports invalidation of single intervals and of the whole table.
- Provides `NUM_PORTS` independent registered range lookups.
- Sits beside the load/store path: the overflow detector writes intervals, memory-access checkers query them.

## Interface
- `ADDR_W`, 32: address width in bits.
- `DEPTH`, 8: number of interval entries; power of two, ≥2.
- `NUM_PORTS`, 2: number of lookup channels, ≥1.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `wr_valid_i` in 1: write request.
- `wr_ready_o` out 1: write accepted when `wr_valid_i & wr_ready_o`.
- `wr_first_i` in `ADDR_W`: first address of the interval (inclusive).
- `wr_last_i` in `ADDR_W`: last address of the interval (inclusive).
- `wr_err_o` out 1: registered pulse; the accepted write had `first > last` and was dropped.
- `clr_valid_i` in 1: invalidate every valid entry whose first address equals `clr_addr_i`.
- `clr_addr_i` in `ADDR_W`: address matched by a clear.
- `flush_i` in 1: invalidate all entries.
- `lk_valid_i` in `NUM_PORTS`: per-port lookup request.
- `lk_addr_i` in `NUM_PORTS*ADDR_W`: port p uses bits `[p*ADDR_W +: ADDR_W]`.
- `lk_valid_o` out `NUM_PORTS`: lookup result valid.
- `lk_in_range_o` out `NUM_PORTS`: address lies in some valid interval.
- `lk_is_first_o` out `NUM_PORTS`: address equals the first address of some valid interval.
- `count_o` out `$clog2(DEPTH+1)`: number of valid entries.
- `full_o` out 1: `count_o == DEPTH`.
- `overwrite_o` out 1: registered pulse; the accepted write replaced a valid entry.

## Operation
- **Storage:** per entry, valid bit, first and last address; replacement cursor of `$clog2(DEPTH)` bits.
- **Range test:** unsigned, inclusive, `first <= addr <= last`. Only valid entries participate.
- **Write acceptance:** `wr_ready_o = !flush_i`; 0 while `rst_ni` is low.
- **Write with `first > last`:** table unchanged, `wr_err_o` pulses.
- **Write placement:**
  - If a free entry exists, the write goes to the lowest-index free entry; cursor unchanged.
  - If the table is full, the write goes to the entry at the cursor, cursor increments and wraps `DEPTH-1 -> 0`, and `overwrite_o` pulses.
- **Clear:** invalidates all matching entries, zero or more, in one cycle; cursor unchanged.
- **Flush:** invalidates all entries and resets the cursor to 0.
- **Priority in one cycle:**
  - flush beats everything; the write is not accepted because ready is low.
  - clear and write together: the clear acts on pre-existing entries only, and the free-slot search sees entries freed by that clear, so a write never overwrites while the clear frees a slot.
  - A newly written interval is never cleared in its own write cycle.
- **Counter:** `count_o` tracks the valid bits exactly, including simultaneous clear+write; never exceeds `DEPTH`.

## Timing
- **Lookup latency:** 1 cycle. `lk_*_o` at edge n+1 reflect the table contents before the edge-n update (old data).
- **Idle ports:** when `lk_valid_i[p]=0`, `lk_valid_o[p]`, `lk_in_range_o[p]` and `lk_is_first_o[p]` are 0 next cycle.
- **Write visibility:**
  - Table, `count_o` and `full_o` update at the accepting edge.
  - A lookup issued in the cycle after acceptance sees the new interval.
- **Pulse timing:** `wr_err_o` and `overwrite_o` are high for exactly the one cycle after the accepting edge.
- **Reset values:** all entries invalid, cursor 0, every output 0.
- **Reset mid-operation:** immediately invalidates all entries and drops any in-flight lookup result; no pulse is emitted.

## Configuration
- **`OIT_DEDUP_EN` defined:** an accepted write whose (first, last) exactly equals an already-valid entry is absorbed.
  - No slot is allocated, the cursor does not move, `count_o` is unchanged, and `overwrite_o` stays 0.
- **`OIT_DEDUP_EN` undefined:** duplicates occupy separate entries per the placement rules.

## Test plan
- **Basic write and lookup:** reset, write [0x1000,0x10FF], then look up 0x1000 / 0x1080 / 0x1100 on port 0.
  - -> one cycle later, in_range = 1/1/0 and is_first = 1/0/0; `count_o`=1.
- **Full-table replacement:** write `DEPTH`+2 distinct intervals (DEPTH=8).
  - -> `full_o`=1 after the 8th write; the 9th and 10th overwrite entries 0 and 1 with `overwrite_o` pulses; a lookup of the first interval then misses.
- **Clear plus write:** with a full table, clear first=0x2000 (entry 3) and write [0x9000,0x9010] in the same cycle.
  - -> the write lands in entry 3, no `overwrite_o`, `count_o` stays 8.
- **Malformed write and flush:** write [0x50,0x40]. -> `wr_err_o` pulse, `count_o` unchanged.
  - Then `flush_i` together with `wr_valid_i`. -> `wr_ready_o`=0, `count_o`=0, and a subsequent lookup misses.
- **Dual-port lookup with concurrent write:** port 0 queries 0x3000 and port 1 queries 0x4000 in the same cycle as the write of [0x3000,0x3000].
  - -> both miss (old data); repeating the query next cycle gives a port 0 hit.
- **Dedup and reset:** with `OIT_DEDUP_EN`, write [0x10,0x20] twice. -> `count_o`=1; without the macro, 2.
  - Then assert `rst_ni` low mid-lookup. -> all outputs 0 next cycle.
